// File: rtl/bch_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bch_pkg                                                                  |
// | Shared constants and types for the BCH(63,51) encoder scheduler.         |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package bch_pkg;

    localparam int MSG_LEN = 51;
    localparam int CW_LEN  = 63;
    localparam int PAR_LEN = CW_LEN - MSG_LEN;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        GRANT = 3'd1,
        MSG   = 3'd2,
        PAR   = 3'd3,
        GAP   = 3'd4
    } sched_state_t;

    typedef logic chan_t;

    localparam chan_t CH0 = 1'b0;
    localparam chan_t CH1 = 1'b1;

endpackage : bch_pkg
`default_nettype wire

// File: rtl/bch_rr_arb2.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bch_rr_arb2                                                              |
// | Two-input round-robin arbiter; registered last-grant pointer.            |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module bch_rr_arb2
    import bch_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       upd,
    output chan_t      gnt_ch,
    output logic       gnt_any
);

    // Reset value CH1 makes channel 0 win the first tie.
    chan_t r_last;

    always_comb begin
        gnt_any = |req;
        if (req == 2'b11) begin
            gnt_ch = ~r_last;
        end else begin
            gnt_ch = req[1] ? CH1 : CH0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= CH1;
        end else if (upd && gnt_any) begin
            r_last <= gnt_ch;
        end
    end

endmodule : bch_rr_arb2
`default_nettype wire

// File: rtl/bch_enc_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bch_enc_scheduler                                                        |
// | Shares one serial BCH(63,51) encoder between two message sources and    |
// | tags its coded stream. BCH_SCHED_STATS_EN adds per-channel frame counts. |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module bch_enc_scheduler
    import bch_pkg::*;
#(
    parameter int GAP_CYCLES = 0
)
(
    input  logic               clk,
    input  logic               rst,
    input  logic               req0_valid,
    input  logic [MSG_LEN-1:0] req0_data,
    output logic               req0_ready,
    input  logic               req1_valid,
    input  logic [MSG_LEN-1:0] req1_data,
    output logic               req1_ready,
    output logic               enc_en,
    output logic               enc_phase,
    output logic               enc_bit,
    output logic               enc_clr,
    input  logic               enc_cw_bit,
    input  logic               out_ready,
    output logic               out_valid,
    output logic               out_bit,
    output logic               out_sof,
    output logic               out_eof,
    output logic               out_ch
`ifdef BCH_SCHED_STATS_EN
    ,
    output logic [15:0]        frame_cnt0,
    output logic [15:0]        frame_cnt1
`endif
);

    localparam logic [5:0] c_msg_last = 6'(MSG_LEN - 1);
    localparam logic [5:0] c_cw_last  = 6'(CW_LEN - 1);
    localparam logic [3:0] c_gap_last = 4'(GAP_CYCLES - 1);
    localparam bit         c_has_gap  = (GAP_CYCLES > 0);

    sched_state_t       r_state, w_next;
    logic [MSG_LEN-1:0] r_shreg;
    logic [5:0]         r_bit_cnt;
    logic [3:0]         r_gap_cnt;
    chan_t              r_ch;

    logic  w_gnt_any;
    chan_t w_gnt_ch;
    logic  w_enc_en, w_enc_phase, w_enc_bit, w_enc_clr, w_rdy0, w_rdy1;

    logic  r_out_valid, r_out_sof, r_out_eof;
    chan_t r_out_ch;

    bch_rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     ({req1_valid, req0_valid}),
        .upd     (r_state == GRANT),
        .gnt_ch  (w_gnt_ch),
        .gnt_any (w_gnt_any)
    );

    // Arbitration is re-evaluated in GRANT so a source that dropped valid is not served.
    always_comb begin
        w_next      = r_state;
        w_enc_en    = 1'b0;
        w_enc_phase = 1'b0;
        w_enc_bit   = 1'b0;
        w_enc_clr   = 1'b0;
        w_rdy0      = 1'b0;
        w_rdy1      = 1'b0;
        case (r_state)
            IDLE: begin
                if (req0_valid || req1_valid) w_next = GRANT;
            end
            GRANT: begin
                if (w_gnt_any) begin
                    w_enc_clr = 1'b1;
                    w_rdy0    = (w_gnt_ch == CH0);
                    w_rdy1    = (w_gnt_ch == CH1);
                    w_next    = MSG;
                end else begin
                    w_next = IDLE;
                end
            end
            MSG: begin
                w_enc_en  = out_ready;
                w_enc_bit = r_shreg[MSG_LEN-1];
                if (out_ready && (r_bit_cnt == c_msg_last)) w_next = PAR;
            end
            PAR: begin
                w_enc_en    = out_ready;
                w_enc_phase = 1'b1;
                if (out_ready && (r_bit_cnt == c_cw_last)) w_next = c_has_gap ? GAP : IDLE;
            end
            GAP: begin
                if (r_gap_cnt == c_gap_last) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // bit_cnt runs 0..62 across MSG and PAR, so it doubles as the codeword bit index.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_shreg   <= '0;
            r_bit_cnt <= '0;
            r_gap_cnt <= '0;
            r_ch      <= CH0;
        end else begin
            r_state <= w_next;
            case (r_state)
                GRANT: begin
                    if (w_gnt_any) begin
                        r_shreg   <= (w_gnt_ch == CH1) ? req1_data : req0_data;
                        r_ch      <= w_gnt_ch;
                        r_bit_cnt <= '0;
                    end
                end
                MSG: begin
                    if (out_ready) begin
                        r_shreg   <= {r_shreg[MSG_LEN-2:0], 1'b0};
                        r_bit_cnt <= r_bit_cnt + 6'd1;
                    end
                end
                PAR: begin
                    if (out_ready) r_bit_cnt <= r_bit_cnt + 6'd1;
                end
                default: ;
            endcase
            r_gap_cnt <= (r_state == GAP) ? r_gap_cnt + 4'd1 : 4'd0;
        end
    end

    // Tags lag enc_en by one cycle to line up with the encoder's registered output.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_sof   <= 1'b0;
            r_out_eof   <= 1'b0;
            r_out_ch    <= CH0;
        end else begin
            r_out_valid <= w_enc_en;
            r_out_sof   <= w_enc_en && (r_state == MSG) && (r_bit_cnt == 6'd0);
            r_out_eof   <= w_enc_en && (r_state == PAR) && (r_bit_cnt == c_cw_last);
            r_out_ch    <= r_ch;
        end
    end

    assign req0_ready = w_rdy0;
    assign req1_ready = w_rdy1;
    assign enc_en     = w_enc_en;
    assign enc_phase  = w_enc_phase;
    assign enc_bit    = w_enc_bit;
    assign enc_clr    = w_enc_clr;
    assign out_valid  = r_out_valid;
    assign out_bit    = r_out_valid & enc_cw_bit;
    assign out_sof    = r_out_sof;
    assign out_eof    = r_out_eof;
    assign out_ch     = r_out_ch;

`ifdef BCH_SCHED_STATS_EN
    logic [15:0] r_frame_cnt0, r_frame_cnt1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame_cnt0 <= '0;
            r_frame_cnt1 <= '0;
        end else if (r_out_eof) begin
            if (r_out_ch == CH0) r_frame_cnt0 <= r_frame_cnt0 + 16'd1;
            else                 r_frame_cnt1 <= r_frame_cnt1 + 16'd1;
        end
    end

    assign frame_cnt0 = r_frame_cnt0;
    assign frame_cnt1 = r_frame_cnt1;
`endif

endmodule : bch_enc_scheduler
`default_nettype wire

// File: tb/tb_bch_enc_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_bch_enc_scheduler                                                     |
// | Scoreboard bench with a behavioural BCH(63,51) encoder in the loop.      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_bch_enc_scheduler;

    localparam int          TB_GAP = 3;
    localparam logic [12:0] G_FULL = 13'h1539;   // x^12+x^10+x^8+x^5+x^4+x^3+1
    localparam logic [11:0] G_LOW  = 12'h539;

    logic clk = 1'b0;
    logic rst;
    logic req0_valid, req1_valid, req0_ready, req1_ready;
    logic [50:0] req0_data, req1_data;
    logic enc_en, enc_phase, enc_bit, enc_clr;
    logic enc_cw_bit = 1'b0;
    logic out_ready, out_valid, out_bit, out_sof, out_eof, out_ch;
`ifdef BCH_SCHED_STATS_EN
    logic [15:0] frame_cnt0, frame_cnt1;
`endif

    always #5 clk = ~clk;

    bch_enc_scheduler #(.GAP_CYCLES(TB_GAP)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .enc_en     (enc_en),
        .enc_phase  (enc_phase),
        .enc_bit    (enc_bit),
        .enc_clr    (enc_clr),
        .enc_cw_bit (enc_cw_bit),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_bit    (out_bit),
        .out_sof    (out_sof),
        .out_eof    (out_eof),
        .out_ch     (out_ch)
`ifdef BCH_SCHED_STATS_EN
        ,
        .frame_cnt0 (frame_cnt0),
        .frame_cnt1 (frame_cnt1)
`endif
    );

    // Behavioural LFSR encoder standing in for the external encoder.
    logic [11:0] enc_rem;
    always @(posedge clk) begin
        if (enc_clr) begin
            enc_rem <= '0;
        end else if (enc_en) begin
            if (!enc_phase) begin
                enc_rem    <= {enc_rem[10:0], 1'b0} ^ ((enc_bit ^ enc_rem[11]) ? G_LOW : 12'h000);
                enc_cw_bit <= enc_bit;
            end else begin
                enc_rem    <= {enc_rem[10:0], 1'b0};
                enc_cw_bit <= enc_rem[11];
            end
        end
    end

    typedef struct packed { logic ch; logic sof; logic eof; logic b; } beat_t;
    beat_t sb[$];
    logic  msg_q[$];
    logic  exp_ch[$];
    logic  grant_log[$];
    int    grant_cyc[$];
    int    eof_cyc_q[$];

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int msg_seen, par_seen, beats, sof_cyc, eof_cyc, clr_cyc, first_en_cyc;
    logic rand_rdy = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference parity by polynomial long division.
    function automatic logic [11:0] bch_parity(input logic [50:0] m);
        logic [62:0] p;
        p = {m, 12'h000};
        for (int i = 62; i >= 12; i--) begin
            if (p[i]) p[i -: 13] = p[i -: 13] ^ G_FULL;
        end
        return p[11:0];
    endfunction

    task automatic push_frame(input logic ch, input logic [50:0] d);
        logic [11:0] par;
        beat_t e;
        par = bch_parity(d);
        for (int k = 0; k < 63; k++) begin
            e.ch  = ch;
            e.sof = (k == 0);
            e.eof = (k == 62);
            e.b   = (k < 51) ? d[50-k] : par[11-(k-51)];
            sb.push_back(e);
            if (k < 51) msg_q.push_back(d[50-k]);
        end
        exp_ch.push_back(ch);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    end

    always @(negedge clk) begin
        if (!rst) begin
            beat_t e;
            if (enc_clr) clr_cyc = cyc;
            if (!out_ready) check("stall_en", enc_en, 0);
            if (enc_en && !enc_phase) begin
                if (msg_seen == 0) first_en_cyc = cyc;
                if (msg_q.size() == 0) check("enc_bit_extra", 1, 0);
                else check("enc_bit", enc_bit, msg_q.pop_front());
                msg_seen++;
            end
            if (enc_en && enc_phase) par_seen++;
            if (req0_ready || req1_ready) begin
                check("ready_onehot", req0_ready & req1_ready, 0);
                grant_log.push_back(req1_ready);
                grant_cyc.push_back(cyc);
            end
            if (out_valid) begin
                beats++;
                if (out_sof) sof_cyc = cyc;
                if (out_eof) begin eof_cyc = cyc; eof_cyc_q.push_back(cyc); end
                if (sb.size() == 0) begin
                    check("beat_extra", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("out_bit", out_bit, e.b);
                    check("out_sof", out_sof, e.sof);
                    check("out_eof", out_eof, e.eof);
                    check("out_ch", out_ch, e.ch);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_stats();
        sb.delete(); msg_q.delete(); exp_ch.delete();
        grant_log.delete(); grant_cyc.delete(); eof_cyc_q.delete();
        msg_seen = 0; par_seen = 0; beats = 0;
        sof_cyc = -1; eof_cyc = -1; clr_cyc = -1; first_en_cyc = -1;
    endtask

    function automatic logic [10:0] out_vec();
        return {req0_ready, req1_ready, enc_en, enc_phase, enc_bit, enc_clr,
                out_valid, out_bit, out_sof, out_eof, out_ch};
    endfunction

    task automatic do_reset(input string tag);
        rst = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        out_ready  = 1'b1;
        tick();
        check(tag, {53'd0, out_vec()}, 0);
        tick();
        rst = 1'b0;
        clear_stats();
        tick();
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 3000; i++) begin
            if (sb.size() == 0 && msg_q.size() == 0) break;
            tick();
        end
        check(tag, sb.size() + msg_q.size(), 0);
        repeat (TB_GAP + 3) tick();
    endtask

    task automatic run_frame(input logic ch, input logic [50:0] d, output int lat);
        logic got;
        push_frame(ch, d);
        if (ch) begin req1_data = d; req1_valid = 1'b1; end
        else    begin req0_data = d; req0_valid = 1'b1; end
        lat = 0;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            lat++;
            got = ch ? req1_ready : req0_ready;
            if (got) break;
        end
        check("grant_seen", got, 1);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_drain("frame_drain");
    endtask

    // Continuous valid on the enabled channels; each source advances to its next word after its grant.
    task automatic run_burst(input logic v0, input logic v1, input int frames);
        logic [50:0] q0[$];
        logic [50:0] q1[$];
        logic [63:0] r;
        logic ch;
        logic pend0, pend1;
        for (int k = 0; k < frames; k++) begin
            r  = {$urandom, $urandom};
            ch = (v0 && v1) ? 1'(k % 2) : v1;
            push_frame(ch, r[50:0]);
            if (ch) q1.push_back(r[50:0]); else q0.push_back(r[50:0]);
        end
        if (q0.size() > 0) begin req0_data = q0[0]; req0_valid = 1'b1; end
        if (q1.size() > 0) begin req1_data = q1[0]; req1_valid = 1'b1; end
        pend0 = 1'b0;
        pend1 = 1'b0;
        for (int i = 0; i < 2000 && (req0_valid || req1_valid); i++) begin
            tick();
            if (pend0) begin
                void'(q0.pop_front());
                if (q0.size() > 0) req0_data = q0[0]; else req0_valid = 1'b0;
                pend0 = 1'b0;
            end
            if (pend1) begin
                void'(q1.pop_front());
                if (q1.size() > 0) req1_data = q1[0]; else req1_valid = 1'b0;
                pend1 = 1'b0;
            end
            if (req0_ready && req0_valid) pend0 = 1'b1;
            if (req1_ready && req1_valid) pend1 = 1'b1;
        end
        check("burst_done", {62'd0, req1_valid, req0_valid}, 0);
        wait_drain("burst_drain");
        check("grant_count", grant_log.size(), frames);
        for (int k = 0; k < frames && k < grant_log.size(); k++) begin
            check($sformatf("grant_ch[%0d]", k), grant_log[k], exp_ch[k]);
        end
        for (int k = 1; k < grant_cyc.size(); k++) begin
            check($sformatf("grant_period[%0d]", k), grant_cyc[k] - grant_cyc[k-1], 65 + TB_GAP);
            if (k - 1 < eof_cyc_q.size())
                check($sformatf("eof_to_grant[%0d]", k), grant_cyc[k] - eof_cyc_q[k-1], TB_GAP + 1);
        end
    endtask

    initial begin
        int lat;
        logic [63:0] r;
        req0_data = '0;
        req1_data = '0;
        clear_stats();

        // Reset state, then a single channel-0 request.
        do_reset("reset_outputs");
        run_frame(1'b0, 51'h5_5555_5555_5555, lat);
        check("grant_latency", lat, 1);
        check("first_en_after_grant", first_en_cyc - grant_cyc[0], 1);
        check("msg_bits", msg_seen, 51);
        check("par_bits", par_seen, 12);
        check("beats", beats, 63);
        check("sof_to_eof", eof_cyc - sof_cyc, 62);

        // Both sources continuously valid: strict alternation starting at 0.
        do_reset("reset_burst");
        run_burst(1'b1, 1'b1, 4);

        // Random backpressure across a whole frame.
        do_reset("reset_rand");
        rand_rdy = 1'b1;
        r = {$urandom, $urandom};
        run_frame(1'b1, r[50:0], lat);
        rand_rdy = 1'b0;
        out_ready = 1'b1;
        check("rand_beats", beats, 63);
        check("rand_msg_bits", msg_seen, 51);
        check("rand_par_bits", par_seen, 12);

        // Reset in the middle of the message phase.
        do_reset("reset_mid_pre");
        r = {$urandom, $urandom};
        push_frame(1'b0, r[50:0]);
        req0_data = r[50:0];
        req0_valid = 1'b1;
        for (int i = 0; i < 200 && msg_seen < 20; i++) begin
            tick();
            if (req0_ready) begin tick(); req0_valid = 1'b0; end
        end
        check("reached_bit20", msg_seen >= 20, 1);
        rst = 1'b1;
        req0_valid = 1'b0;
        tick();
        check("rst_mid_outputs", {53'd0, out_vec()}, 0);
        tick();
        rst = 1'b0;
        clear_stats();
        tick();
        r = {$urandom, $urandom};
        run_frame(1'b1, r[50:0], lat);
        check("clr_before_en", first_en_cyc - clr_cyc, 1);
        check("post_rst_beats", beats, 63);

        // Back-to-back on one channel exercises the inter-codeword gap.
        do_reset("reset_gap");
        run_burst(1'b0, 1'b1, 2);

`ifdef BCH_SCHED_STATS_EN
        do_reset("reset_stats");
        for (int k = 0; k < 3; k++) begin r = {$urandom, $urandom}; run_frame(1'b0, r[50:0], lat); end
        for (int k = 0; k < 2; k++) begin r = {$urandom, $urandom}; run_frame(1'b1, r[50:0], lat); end
        check("frame_cnt0", frame_cnt0, 3);
        check("frame_cnt1", frame_cnt1, 2);
        force dut.r_frame_cnt0 = 16'hFFFF;
        tick();
        release dut.r_frame_cnt0;
        tick();
        r = {$urandom, $urandom};
        run_frame(1'b0, r[50:0], lat);
        check("frame_cnt0_wrap", frame_cnt0, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_bch_enc_scheduler
`default_nettype wire
